// File: rtl/equiv_pkg.sv
// equiv_pkg: shared types and defaults for the equivalence monitor.
package equiv_pkg;

    localparam int DEF_WIDTH = 91;
    localparam int DEF_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_CHECK  = 2'd2,
        ST_FAIL   = 2'd3
    } state_t;

    // Stages needed to bring a side with latency own_lat in line with the
    // other side; the faster side is the one that gets delayed.
    function automatic int align_depth(input int own_lat, input int other_lat);
        return (other_lat > own_lat) ? (other_lat - own_lat) : 0;
    endfunction

endpackage

// File: rtl/equiv_delay.sv
// equiv_delay: fixed-depth alignment delay line. DEPTH=0 is a plain wire.
module equiv_delay
    import equiv_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_wire
            // Clock and reset have no load here; fold them into a sink so the
            // wire build carries no dangling inputs.
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst_n;
            assign q = d;
        end else begin : g_pipe
            logic [WIDTH-1:0] pipe [DEPTH];

            // Free-running shift register, independent of monitor state
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
                end else begin
                    pipe[0] <= d;
                    for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
                end
            end

            assign q = pipe[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/equiv_monitor.sv
// equiv_monitor: lock-step comparison of two implementations with different
// pipeline latencies. Optional first-mismatch capture is built in when the
// macro EQUIV_MONITOR_CAPTURE_EN is defined; otherwise first_cyc/first_diff
// read 0 and no capture registers exist.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | disarmed, nothing compared
// ST_WARMUP | armed, ignoring WARMUP aligned cycles while pipes settle
// ST_CHECK  | comparing, no mismatch seen since reset/clear
// ST_FAIL   | comparing, at least one mismatch seen (sticky until clear)
module equiv_monitor
    import equiv_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int LAT_1  = 0,
    parameter int LAT_2  = 0,
    parameter int WARMUP = 4,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clear,
    input  logic [WIDTH-1:0] y_1,
    input  logic [WIDTH-1:0] y_2,
    input  logic [WIDTH-1:0] mask,
    output logic             mismatch,
    output logic             fail,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] first_cyc,
    output logic [WIDTH-1:0] first_diff
);

    localparam int DLY_1 = align_depth(LAT_1, LAT_2);
    localparam int DLY_2 = align_depth(LAT_2, LAT_1);
    localparam int WU_W  = (WARMUP < 2) ? 1 : $clog2(WARMUP);

    logic [WIDTH-1:0] y_1_al;
    logic [WIDTH-1:0] y_2_al;
    logic [WIDTH-1:0] diff;
    logic             hit;
    logic             cmp_act;
    logic             cmp_hit;
    state_t           state;
    logic [WU_W-1:0]  wu_cnt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    equiv_delay #(.WIDTH(WIDTH), .DEPTH(DLY_1)) u_dly_1 (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (y_1),
        .q     (y_1_al)
    );

    equiv_delay #(.WIDTH(WIDTH), .DEPTH(DLY_2)) u_dly_2 (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (y_2),
        .q     (y_2_al)
    );

    // The mask travels with the slower side, which is never delayed, so it is
    // applied at the compare instant as presented.
    assign diff    = (y_1_al ^ y_2_al) & ~mask;
    assign hit     = |diff;
    assign cmp_act = en && ((state == ST_CHECK) || (state == ST_FAIL));
    assign cmp_hit = cmp_act && hit && !clear;

    // Arming sequence with warm-up down-counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            wu_cnt <= '0;
        end else if (!en) begin
            state  <= ST_IDLE;
            wu_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (WARMUP == 0) begin
                        state <= ST_CHECK;
                    end else begin
                        state  <= ST_WARMUP;
                        wu_cnt <= WU_W'(WARMUP - 1);
                    end
                end
                ST_WARMUP: begin
                    if (wu_cnt == '0) state <= ST_CHECK;
                    else              wu_cnt <= wu_cnt - WU_W'(1);
                end
                ST_CHECK: begin
                    if (cmp_hit) state <= ST_FAIL;
                end
                ST_FAIL: begin
                    if (clear) state <= ST_CHECK;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Registered compare results; clear wins over a same-cycle mismatch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mismatch <= 1'b0;
            fail     <= 1'b0;
            err_cnt  <= '0;
            cyc_cnt  <= '0;
        end else if (clear) begin
            mismatch <= 1'b0;
            fail     <= 1'b0;
            err_cnt  <= '0;
            cyc_cnt  <= '0;
        end else begin
            mismatch <= cmp_hit;
            if (cmp_act) begin
                cyc_cnt <= sat_inc(cyc_cnt);
                if (hit) begin
                    err_cnt <= sat_inc(err_cnt);
                    fail    <= 1'b1;
                end
            end
        end
    end

`ifdef EQUIV_MONITOR_CAPTURE_EN
    logic [CNT_W-1:0] cap_cyc;
    logic [WIDTH-1:0] cap_diff;

    // Snapshot of the first mismatch; first_cyc matches cyc_cnt as it reads
    // alongside that mismatch pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_cyc  <= '0;
            cap_diff <= '0;
        end else if (clear) begin
            cap_cyc  <= '0;
            cap_diff <= '0;
        end else if (cmp_hit && !fail) begin
            cap_cyc  <= sat_inc(cyc_cnt);
            cap_diff <= diff;
        end
    end

    assign first_cyc  = cap_cyc;
    assign first_diff = cap_diff;
`else
    assign first_cyc  = '0;
    assign first_diff = '0;
`endif

endmodule

// File: doc/equiv_monitor.md
EQUIV_MONITOR -- requirements
Module: equiv_monitor

Interface
REQ-001 Parameter WIDTH, default 91: width of each compared output vector.
REQ-002 Parameter LAT_1, default 0: pipeline latency of implementation 1, in cycles.
REQ-003 Parameter LAT_2, default 0: pipeline latency of implementation 2, in cycles.
REQ-004 Parameter WARMUP, default 4: number of aligned cycles ignored after arming.
REQ-005 Parameter CNT_W, default 16: width of the error and cycle counters.
REQ-006 Port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-007 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-008 Port en, input, 1 bit: arm the checker; deasserting it returns the checker to IDLE.
REQ-009 Port clear, input, 1 bit: synchronous clear of counters, sticky flag and capture.
REQ-010 Port y_1, input, WIDTH bits: output of implementation 1.
REQ-011 Port y_2, input, WIDTH bits: output of implementation 2.
REQ-012 Port mask, input, WIDTH bits: a bit set to 1 excludes that bit from comparison; sampled with the later-aligned side.
REQ-013 Port mismatch, output, 1 bit: single-cycle pulse for each mismatching compare.
REQ-014 Port fail, output, 1 bit: sticky flag, set on the first mismatch.
REQ-015 Port err_cnt, output, CNT_W bits: saturating count of mismatches.
REQ-016 Port cyc_cnt, output, CNT_W bits: saturating count of compared cycles in CHECK.
REQ-017 Port first_cyc, output, CNT_W bits: value of cyc_cnt at the first mismatch.
REQ-018 Port first_diff, output, WIDTH bits: masked XOR of y_1 and y_2 at the first mismatch.

Function
REQ-019 Alignment: the side with the smaller latency SHALL be delayed by |LAT_1-LAT_2| register stages; zero stages when the latencies are equal.
REQ-020 Compare term: diff = (y_1_aligned ^ y_2_aligned) & ~mask_aligned; a mismatch is any bit of diff being 1.
REQ-021 FSM states: IDLE, WARMUP, CHECK, FAIL.
REQ-022 IDLE -> WARMUP when en=1; WARMUP -> CHECK after WARMUP cycles with en=1 (WARMUP=0 goes straight to CHECK); any state -> IDLE when en=0.
REQ-023 CHECK -> FAIL on the first mismatch; FAIL keeps comparing and counting; FAIL -> CHECK only on clear with en=1.
REQ-024 Comparisons SHALL count only in CHECK and FAIL; diff computed in IDLE or WARMUP SHALL be ignored.
REQ-025 mismatch, err_cnt, cyc_cnt and fail SHALL be registered, so they reflect the aligned compare one cycle later.
REQ-026 Both counters SHALL saturate at all-ones and never wrap.
REQ-027 clear takes priority over a same-cycle mismatch: counters and capture go to 0, fail goes to 0, and that cycle's mismatch is dropped.
REQ-028 en=0 SHALL hold the counters, fail and capture; only the FSM and warm-up count reset.
REQ-029 The delay line SHALL shift every cycle regardless of state, so alignment stays valid across re-arming.

Reset
REQ-030 While rst_n=0: FSM is in IDLE, all outputs are 0, and all delay-line and warm-up registers are 0.
REQ-031 Reset asserted mid-operation SHALL clear state immediately, with no clock required.

Configuration
REQ-032 Macro EQUIV_MONITOR_CAPTURE_EN defined: first_cyc and first_diff load on the first mismatch after reset or clear, then hold.
REQ-033 Macro EQUIV_MONITOR_CAPTURE_EN undefined: first_cyc and first_diff are tied to 0 and no capture registers exist.

Structure
REQ-034 Package equiv_pkg SHALL hold the FSM state typedef and the default WIDTH and CNT_W constants.
REQ-035 Sub-module equiv_delay (parameters WIDTH and DEPTH; DEPTH=0 means a wire) SHALL implement the alignment delay, instantiated once per side.

Verification
REQ-036 WIDTH=8, LAT_1=LAT_2=0, WARMUP=0, y_1=y_2 for 100 cycles -> fail=0, err_cnt=0, cyc_cnt=100.
REQ-037 LAT_1=2, LAT_2=0, y_2 driven as y_1 advanced by 2 cycles -> no mismatch; the same stream with LAT_1=1 -> fail=1.
REQ-038 Bit 3 differs for 5 cycles, mask=0x08 -> err_cnt=0; mask=0 -> err_cnt=5, mismatch high for 5 cycles.
REQ-039 Mismatches only during the first 4 cycles after en rises, WARMUP=4 -> fail=0.
REQ-040 CNT_W=4, 20 mismatches -> err_cnt=15; clear asserted together with a mismatch -> err_cnt=0, fail=0.
REQ-041 With EQUIV_MONITOR_CAPTURE_EN: first mismatch diff=0x21 at cyc_cnt=7, later diff=0xFF -> first_diff=0x21, first_cyc=7; rst_n pulsed mid-run -> all outputs 0 before the next clock edge.
